// File: rtl/cbus_rr_arbiter_pkg.sv
// ============================================================================
// Module  : cbus_rr_arbiter_pkg
// Brief   : cbus request/response types and arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    MLEN1 = 2'd0,
    MLEN2 = 2'd1,
    MLEN4 = 2'd2,
    MLEN8 = 2'd3
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    cbus_len_t   len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic        err;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic cbus_done(input cbus_resp_t r);
    return r.ready & r.last;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cbus_rr_arbiter_if.sv
// ============================================================================
// Module  : cbus_rr_arbiter_if
// Brief   : Requester-side and memory-side cbus bundle of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cbus_rr_arbiter_if
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  localparam int IDX_W = idx_width(NUM_REQ);

  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;
  logic       [IDX_W-1:0]   grant_idx;
  logic                     busy;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq,
    output grant_idx,
    output busy
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq,
    input  grant_idx,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// ============================================================================
// Module  : cbus_rr_arbiter_rr_pick
// Brief   : Combinational round-robin search: first valid at or above ptr, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_rr_arbiter_rr_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  wire logic [N-1:0]              valid,
  input  wire logic [idx_width(N)-1:0]   ptr,
  output logic                           any,
  output logic      [idx_width(N)-1:0]   idx
);

  localparam int IDX_W = idx_width(N);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest valid entry wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (valid[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
// ============================================================================
// Module  : cbus_rr_arbiter
// Brief   : Round-robin share of one cbus master port among NUM_REQ requesters,
//           grant held until last beat, then released through an idle gap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 1
) (
  input wire logic             clk,
  input wire logic             reset,
  cbus_rr_arbiter_if.slave     bus
);

  localparam int                IDX_W      = idx_width(NUM_REQ);
  localparam int                GAP_W      = idx_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  C_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_busy;

  logic [NUM_REQ-1:0] w_valid;
  logic               w_any;
  logic [IDX_W-1:0]   w_pick;
  logic               w_done;
  logic               w_hold;
  logic [IDX_W-1:0]   w_next_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
    assign w_valid[gi] = bus.ireqs[gi].valid;
  end

  cbus_rr_arbiter_rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .valid (w_valid),
    .ptr   (r_rr_ptr),
    .any   (w_any),
    .idx   (w_pick)
  );

  assign w_done     = cbus_done(bus.oresp);
  assign w_hold     = bus.ireqs[r_grant_idx].valid;
  assign w_next_ptr = (r_grant_idx == C_LAST_IDX) ? '0 : r_grant_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state     <= ARB_BUSY;
            r_grant_idx <= w_pick;
            r_busy      <= 1'b1;
          end
        end
        // Completion and abandonment both release the port the same way.
        ARB_BUSY: begin
          if (w_done || !w_hold) begin
            r_state   <= ARB_GAP;
            r_rr_ptr  <= w_next_ptr;
            r_gap_cnt <= C_GAP_LOAD;
            r_busy    <= 1'b0;
          end
        end
        ARB_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ARB_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.oreq   = '0;
    bus.iresps = '0;
    if (r_state == ARB_BUSY) begin
      if (w_hold) begin
        bus.oreq = bus.ireqs[r_grant_idx];
      end
      bus.iresps[r_grant_idx] = bus.oresp;
    end
  end

  assign bus.grant_idx = r_grant_idx;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire
